// File: rtl/load_store_unit.sv
// Byte-addressed RISC-V load/store sequencer in front of a word-only DataMemory.
// Sub-word stores become a read cycle followed by a merged write cycle.
module load_store_unit #(
  parameter int Width     = 32,
  parameter int AddrWidth = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             we,
  input  logic [2:0]       funct3,
  input  logic [Width-1:0] addr,
  input  logic [Width-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [Width-1:0] rdata,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [Width-1:0] MemAddr,
  output logic [Width-1:0] MemWData,
  input  logic [Width-1:0] MemRData
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    FAULT  = 3'd5
  } state_t;

  state_t state, state_nx;

  logic [1:0]       off_q;
  logic [2:0]       f3_q;
  logic [15:0]      wdata_q;
  logic             illegal, misaligned;
  logic             done_nx, err_nx;
  logic [7:0]       byte_l;
  logic [15:0]      half_l;
  logic [Width-1:0] load_ext;
  logic [Width-1:0] merged;
  logic             unused_addr_hi;

  // Byte offset and address bits above the word index never reach memory.
  assign unused_addr_hi = ^addr[Width-1:AddrWidth+2];

  always_comb begin
    illegal    = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3 == 3'd2) && (addr[1:0] != 2'b00));
  end

  always_comb begin
    state_nx = state;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (illegal || misaligned)  state_nx = FAULT;
          else if (!we)               state_nx = LOAD;
          else if (funct3 == 3'd2)    state_nx = STORE;
          else                        state_nx = RMW_RD;
        end
      end
      LOAD: begin
        MemRead  = 1'b1;
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
      STORE: begin
        MemWrite = 1'b1;
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
      RMW_RD: begin
        MemRead  = 1'b1;
        state_nx = RMW_WR;
      end
      RMW_WR: begin
        MemWrite = 1'b1;
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
      FAULT: begin
        state_nx = IDLE;
        done_nx  = 1'b1;
        err_nx   = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Lane select and extension of the word returned during LOAD.
  always_comb begin
    byte_l = MemRData[{off_q, 3'b000} +: 8];
    half_l = MemRData[{off_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'd0:    load_ext = {{(Width-8){byte_l[7]}}, byte_l};
      3'd1:    load_ext = {{(Width-16){half_l[15]}}, half_l};
      3'd4:    load_ext = {{(Width-8){1'b0}}, byte_l};
      3'd5:    load_ext = {{(Width-16){1'b0}}, half_l};
      default: load_ext = MemRData;
    endcase
  end

  always_comb begin
    merged = MemRData;
    if (f3_q[1:0] == 2'b00) merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    else                    merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
  end

  assign busy = (state != IDLE);

  // MemWData doubles as the merge register: the RMW read captures the merged word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      done     <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      MemAddr  <= '0;
      MemWData <= '0;
      off_q    <= '0;
      f3_q     <= '0;
      wdata_q  <= '0;
    end else begin
      state <= state_nx;
      done  <= done_nx;
      err   <= err_nx;
      if (state == IDLE && req) begin
        off_q   <= addr[1:0];
        f3_q    <= funct3;
        wdata_q <= wdata[15:0];
        MemAddr <= {{(Width-AddrWidth){1'b0}}, addr[AddrWidth+1:2]};
        if (state_nx == STORE) MemWData <= wdata;
      end
      if (state == LOAD)   rdata    <= load_ext;
      if (state == RMW_RD) MemWData <= merged;
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencer between the execute stage and the word-only `DataMemory` block. It turns byte-addressed RISC-V loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-indexed `MemRead`/`MemWrite`/`ALUResult`/`WriteData` accesses. Sub-word stores are done as a two-cycle read-modify-write. Load data is sign- or zero-extended and registered, and misaligned or illegal requests are flagged with no memory access.

## Interface
- `Width`, 32: data and address width.
- `AddrWidth`, 9: word-index width; 512 words, matching DataMemory depth.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  request strobe; sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load.
- `funct3`  in  3  RISC-V width/sign code: 0 B, 1 H, 2 W, 4 BU, 5 HU.
- `addr`  in  Width  byte address (ALU result).
- `wdata`  in  Width  store data (RS2).
- `busy`  out  1  high when state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse coincident with `done` for misaligned or illegal requests.
- `rdata`  out  Width  registered, extended load result.
- `MemRead`  out  1  to DataMemory.
- `MemWrite`  out  1  to DataMemory.
- `MemAddr`  out  Width  word index to DataMemory `ALUResult`: `{0, addr[AddrWidth+1:2]}`.
- `MemWData`  out  Width  to DataMemory `WriteData`.
- `MemRData`  in  Width  from DataMemory `ReadData`; combinational, valid the same cycle as `MemRead`.

## Operation
- **States:** IDLE, LOAD, STORE, RMW_RD, RMW_WR, FAULT.
- **Acceptance (IDLE, req=1, at the clock edge):**
  - Latch `addr[1:0]`, word index, `funct3`, `wdata`.
  - Check the request:
    - Illegal: `funct3` ∈ {3, 6, 7}.
    - Misaligned: H/HU/SH with `addr[0]`=1, or W/SW with `addr[1:0]`≠0.
  - Illegal or misaligned → FAULT.
  - Otherwise: load → LOAD; SW → STORE; SB/SH → RMW_RD.
- **`req` while busy:** ignored, not queued.
- **LOAD:**
  - `MemRead`=1.
  - At the edge, `rdata` ← extension of the selected lane:
    - Byte lane = `addr[1:0]`*8; half lane = `addr[1]`*16.
    - B/H sign-extend; BU/HU zero-extend.
  - Next state IDLE, `done`=1.
- **STORE:**
  - `MemWrite`=1, `MemWData`=`wdata`.
  - Next state IDLE, `done`=1.
- **RMW_RD:**
  - `MemRead`=1; capture `MemRData` into an internal merge register.
  - Next state RMW_WR.
- **RMW_WR:**
  - `MemWrite`=1.
  - `MemWData` = merge register with the addressed byte replaced by `wdata[7:0]` (SB), or the addressed half replaced by `wdata[15:0]` (SH). Other lanes are unchanged.
  - Next state IDLE, `done`=1.
- **FAULT:**
  - No memory strobe.
  - Next state IDLE, `done`=1, `err`=1.
  - `rdata` unchanged.
- **Memory strobes:** `MemRead` and `MemWrite` are never both 1, and both are 0 in IDLE and FAULT.
- **`MemAddr` / `MemWData`:** hold their last latched values when idle.
- **Address bits:** bits above `AddrWidth+1` are ignored, so the address wraps modulo 512 words.
- **Store data:** SW uses all 32 bits of `wdata`; SB/SH ignore the upper `wdata` bits.
- **`rdata`:** updates only on load completion.

## Timing
- **Reset values:** state=IDLE, `busy`=0, `done`=0, `err`=0, `rdata`=0, `MemRead`=0, `MemWrite`=0, `MemAddr`=0, `MemWData`=0, merge register 0.
- **Latency** (accept edge = E0):
  - Load, SW, or fault: memory cycle between E0 and E1; `done` high in the cycle after E1.
  - SB/SH: read cycle, then write cycle; `done` high in the cycle after E2.
- **Back-to-back:** `done` is asserted in IDLE, so a new `req` is accepted in the same cycle `done` is high. Throughput is one load per 2 cycles and one SB/SH per 3 cycles.
- **`done`/`err` width:** exactly one cycle each.
- **Reset mid-operation:** asserting `reset` in RMW_RD or RMW_WR aborts immediately. `MemWrite` drops asynchronously, no partial write is issued after reset, and the memory word is unchanged unless the RMW_WR edge was already taken.
- **Read timing:** `MemRData` is sampled at the end of the `MemRead` cycle and must settle within that cycle, since DataMemory reads combinationally.

## Test plan
- **LW:** mem[5]=0x8001_7FFF; req LW addr=0x14 → `MemAddr`=5, `MemRead` for 1 cycle; `done` 2 cycles after accept; `rdata`=0x8001_7FFF, `err`=0.
- **Load extension:** same word; LB addr=0x14 → `rdata`=0xFFFF_FFFF; LBU addr=0x17 → 0x0000_0080; LH addr=0x16 → 0xFFFF_8001; LHU addr=0x14 → 0x0000_7FFF.
- **SB:** mem[3]=0x1122_3344; SB addr=0x0D, wdata=0xAABB_CCDD → `MemRead` cycle, then `MemWrite` with `MemWData`=0x1122_DD44; `done` 3 cycles after accept; mem[3]=0x1122_DD44.
- **SH:** mem[3]=0x1122_3344; SH addr=0x0E, wdata=0x0000_BEEF → mem[3]=0xBEEF_3344; SW addr=0x0C, wdata=0xCAFE_F00D → mem[3]=0xCAFE_F00D after a 1-cycle `MemWrite`.
- **Faults:** LW addr=0x02, SH addr=0x01, funct3=3 → each gives `done`=`err`=1 for 1 cycle, `MemRead`=`MemWrite`=0 throughout, `rdata` unchanged. A second `req` during `busy` is ignored.
- **Reset:** assert `reset` during RMW_RD of SB addr=0x0D → outputs go to reset values immediately, mem[3] unchanged; with `req` held, the next request is accepted on the first edge after `reset` deasserts.
